// File: rtl/hazard_pkg.sv
// Shared encodings and defaults for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_ALU_WAIT = 3'd1,
        ST_MEM_WAIT = 3'd2,
        ST_HALT     = 3'd3
    } state_t;

    localparam int          ALU_LAT_DEFAULT = 8;
    localparam int          REG_W           = 5;
    localparam logic [15:0] STALL_CNT_MAX   = 16'hFFFF;

endpackage

// File: rtl/hazard_lu_detect.sv
// Load-use hazard detection: a load in EX writes a register the ID instruction reads.
module hazard_lu_detect
    import hazard_pkg::*;
(
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_mem_read,
    output logic             load_use
);

    // r0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign load_use = ex_mem_read && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stage enables/flushes for memory stalls, multicycle
// ALU ops, redirects, load-use and halt, plus a saturating stall-cycle counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int ALU_LAT = ALU_LAT_DEFAULT
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_mem_read,
    input  logic             ex_alu_stall,
    input  logic             ex_branch_taken,
    input  logic             ex_jump,
    input  logic             ex_halted,
    input  logic             mem_access,
    input  logic             mem_cache_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic [2:0]       state,
    output logic [15:0]      stall_cnt
);

    localparam logic [7:0] ALU_CNT_LOAD = 8'(ALU_LAT - 2);

    state_t      state_q, state_d;
    state_t      saved_q, saved_d;
    state_t      eff_state;
    logic [7:0]  alu_cnt_q, alu_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        mem_stall;
    logic        load_use;

    hazard_lu_detect u_lu_detect (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_rt       (ex_rt),
        .ex_mem_read (ex_mem_read),
        .load_use    (load_use)
    );

    assign mem_stall = mem_access && !mem_cache_ready;
    // Leaving MEM_WAIT applies the suspended state's rules in the same cycle.
    assign eff_state = (state_q == ST_MEM_WAIT) ? saved_q : state_q;

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        state_d      = state_q;
        saved_d      = saved_q;
        alu_cnt_d    = alu_cnt_q;

        if (state_q == ST_HALT) begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            id_ex_en = 1'b0;
        end else if (mem_stall) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
            state_d   = ST_MEM_WAIT;
            if (state_q != ST_MEM_WAIT) begin
                saved_d = state_q;
            end
        end else begin
            case (eff_state)
                ST_ALU_WAIT: begin
                    if (alu_cnt_q != 8'd0) begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_en     = 1'b0;
                        ex_mem_flush = 1'b1;
                        alu_cnt_d    = alu_cnt_q - 8'd1;
                        state_d      = ST_ALU_WAIT;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    if (ex_alu_stall) begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_en     = 1'b0;
                        ex_mem_flush = 1'b1;
                        alu_cnt_d    = ALU_CNT_LOAD;
                        state_d      = ST_ALU_WAIT;
                    end else if (ex_halted) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                        state_d     = ST_HALT;
                    end else if (ex_branch_taken || ex_jump) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
            endcase
        end

        stall_cnt_d = stall_cnt_q;
        if (!pc_en && (state_q != ST_HALT) && (stall_cnt_q != STALL_CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            saved_q     <= ST_RUN;
            alu_cnt_q   <= 8'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            saved_q     <= saved_d;
            alu_cnt_q   <= alu_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign state     = state_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal checks plus a per-cycle
// occupancy-based reference model compared on every falling edge.
module tb_hazard_ctrl;

    localparam int LAT = 8;

    logic        clk;
    logic        rst_n;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        ex_mem_read, ex_alu_stall, ex_branch_taken, ex_jump, ex_halted;
    logic        mem_access, mem_cache_ready;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, ex_mem_flush;
    logic [2:0]  state;
    logic [15:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    hazard_ctrl #(.ALU_LAT(LAT)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .ex_rt           (ex_rt),
        .ex_mem_read     (ex_mem_read),
        .ex_alu_stall    (ex_alu_stall),
        .ex_branch_taken (ex_branch_taken),
        .ex_jump         (ex_jump),
        .ex_halted       (ex_halted),
        .mem_access      (mem_access),
        .mem_cache_ready (mem_cache_ready),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .id_ex_en        (id_ex_en),
        .ex_mem_en       (ex_mem_en),
        .mem_wb_en       (mem_wb_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_flush    (ex_mem_flush),
        .state           (state),
        .stall_cnt       (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: ALU ops are tracked as cycles of EX occupancy left; a memory stall
    // freezes everything; halt is a sticky flag.
    int   m_left;
    bit   m_mem;
    bit   m_halt;
    int   m_cnt;
    logic [7:0] m_exp;
    logic [2:0] m_state;
    bit   m_ms, m_lu;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_left = 0;
            m_mem  = 0;
            m_halt = 0;
            m_cnt  = 0;
            check("reset_state", {29'd0, state}, 32'd0);
            check("reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        end else begin
            m_state = m_halt ? 3'd3 : m_mem ? 3'd2 : (m_left > 0) ? 3'd1 : 3'd0;
            check("model_state", {29'd0, state}, {29'd0, m_state});
            check("model_stall_cnt", {16'd0, stall_cnt}, m_cnt);
            m_ms = mem_access && !mem_cache_ready;
            m_lu = ex_mem_read && (ex_rt != 0) && (ex_rt == id_rs || ex_rt == id_rt);
            m_exp = 8'b11111_000;
            if (m_halt) begin
                m_exp = 8'b00011_000;
            end else if (m_ms) begin
                m_exp = 8'b00000_000;
                m_mem = 1;
            end else begin
                m_mem = 0;
                if (m_left > 1) begin
                    m_exp = 8'b00011_001;
                    m_left--;
                end else if (m_left == 1) begin
                    m_left = 0;
                end else if (ex_alu_stall) begin
                    m_exp  = 8'b00011_001;
                    m_left = LAT - 1;
                end else if (ex_halted) begin
                    m_exp  = 8'b00111_010;
                    m_halt = 1;
                end else if (ex_branch_taken || ex_jump) begin
                    m_exp = 8'b11111_110;
                end else if (m_lu) begin
                    m_exp = 8'b00111_010;
                end
            end
            check("model_outputs",
                  {24'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                   if_id_flush, id_ex_flush, ex_mem_flush},
                  {24'd0, m_exp});
            if (!m_exp[7] && m_state != 3'd3 && m_cnt < 65535) m_cnt++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_rs = 0; id_rt = 0; ex_rt = 0;
        ex_mem_read = 0; ex_alu_stall = 0; ex_branch_taken = 0;
        ex_jump = 0; ex_halted = 0;
        mem_access = 0; mem_cache_ready = 1;
    endtask

    int  base, n, occ, all0, ok;
    bit  done;

    initial begin
        rst_n = 0;
        clr();
        repeat (2) cyc();
        #1;
        check("por_state", {29'd0, state}, 32'd0);
        rst_n = 1;
        cyc(); cyc();
        check("idle_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        check("idle_pc_en", {31'd0, pc_en}, 32'd1);

        // Load-use on rs for one cycle
        ex_mem_read = 1; ex_rt = 5; id_rs = 5; #1;
        check("lu_pc_en", {31'd0, pc_en}, 32'd0);
        check("lu_if_id_en", {31'd0, if_id_en}, 32'd0);
        check("lu_id_ex_flush", {31'd0, id_ex_flush}, 32'd1);
        cyc(); clr(); #1;
        check("lu_released_pc_en", {31'd0, pc_en}, 32'd1);
        check("lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);

        ex_mem_read = 1; ex_rt = 9; id_rt = 9; id_rs = 3; #1;
        check("lu_rt_pc_en", {31'd0, pc_en}, 32'd0);
        cyc(); clr();

        ex_mem_read = 1; ex_rt = 0; id_rs = 0; #1;
        check("lu_r0_pc_en", {31'd0, pc_en}, 32'd1);
        check("lu_r0_flush", {31'd0, id_ex_flush}, 32'd0);
        cyc(); clr();

        ex_mem_read = 1; ex_rt = 5; id_rs = 5; ex_branch_taken = 1; #1;
        check("br_pc_en", {31'd0, pc_en}, 32'd1);
        check("br_flushes", {29'd0, if_id_flush, id_ex_flush, ex_mem_flush}, 32'b110);
        cyc(); clr();

        ex_jump = 1; #1;
        check("jmp_flushes", {29'd0, if_id_flush, id_ex_flush, ex_mem_flush}, 32'b110);
        cyc(); clr(); #1;
        check("cnt_after_lu", {16'd0, stall_cnt}, 32'd2);

        // Multicycle ALU held for the full latency
        base = stall_cnt; n = 0;
        for (int i = 0; i < LAT; i++) begin
            ex_alu_stall = 1; #1;
            if (!id_ex_en) n++;
            if (i == LAT - 1) check("alu_release_id_ex_en", {31'd0, id_ex_en}, 32'd1);
            cyc();
        end
        clr(); #1;
        check("alu_stall_cycles", n, 32'd7);
        check("alu_stall_cnt_delta", stall_cnt - base, 32'd7);
        check("alu_back_to_run", {29'd0, state}, 32'd0);

        // Memory stall arriving while alu_cnt is 3
        base = stall_cnt; occ = 0; all0 = 0; done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            ex_alu_stall    = (i == 0);
            mem_access      = (i >= 4 && i <= 7);
            mem_cache_ready = !(i >= 4 && i <= 7);
            #1;
            occ++;
            if (i >= 4 && i <= 7 && {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} == 5'b0) all0++;
            if (i == 8) begin
                check("mem_exit_state", {29'd0, state}, 32'd2);
                check("mem_exit_alu_rules", {30'd0, id_ex_en, ex_mem_flush}, 32'b01);
            end
            if (i == 9) check("mem_resumed_alu_wait", {29'd0, state}, 32'd1);
            if (id_ex_en) done = 1;
            cyc();
        end
        clr(); #1;
        check("alu_mem_occupancy", occ, 32'd12);
        check("mem_all_enables_low", all0, 32'd4);
        check("alu_mem_stall_cnt_delta", stall_cnt - base, 32'd11);

        // Reset in the middle of ALU_WAIT
        ex_alu_stall = 1; cyc(); clr(); cyc(); cyc();
        check("pre_reset_alu_wait", {29'd0, state}, 32'd1);
        rst_n = 0; #1;
        check("async_reset_alu_state", {29'd0, state}, 32'd0);
        check("async_reset_alu_cnt", {16'd0, stall_cnt}, 32'd0);
        cyc(); rst_n = 1; cyc(); #1;
        check("post_reset_alu_state", {29'd0, state}, 32'd0);
        check("post_reset_alu_pc_en", {31'd0, pc_en}, 32'd1);

        // Reset in the middle of MEM_WAIT
        mem_access = 1; mem_cache_ready = 0; cyc(); cyc();
        check("pre_reset_mem_wait", {29'd0, state}, 32'd2);
        rst_n = 0; #1;
        check("async_reset_mem_state", {29'd0, state}, 32'd0);
        cyc(); clr(); rst_n = 1; cyc(); #1;
        check("post_reset_mem_state", {29'd0, state}, 32'd0);
        check("post_reset_mem_pc_en", {31'd0, pc_en}, 32'd1);

        // Halt is sticky and ignores every input
        ex_halted = 1; #1;
        check("halt_entry_pc_en", {31'd0, pc_en}, 32'd0);
        check("halt_entry_flush", {31'd0, id_ex_flush}, 32'd1);
        cyc(); clr();
        base = stall_cnt; ok = 0;
        for (int i = 0; i < 20; i++) begin
            mem_access = i[0]; mem_cache_ready = 0;
            ex_alu_stall = 1; ex_branch_taken = 1; ex_mem_read = 1; ex_rt = 7; id_rs = 7;
            #1;
            if (state == 3'd3 && {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} == 5'b00011 &&
                {if_id_flush, id_ex_flush, ex_mem_flush} == 3'b000) ok++;
            cyc();
        end
        clr(); #1;
        check("halt_held_cycles", ok, 32'd20);
        check("halt_stall_cnt_frozen", stall_cnt - base, 32'd0);
        rst_n = 0; #1;
        check("halt_reset_state", {29'd0, state}, 32'd0);
        check("halt_reset_cnt", {16'd0, stall_cnt}, 32'd0);
        cyc(); rst_n = 1; cyc(); #1;
        check("after_halt_state", {29'd0, state}, 32'd0);
        check("after_halt_pc_en", {31'd0, pc_en}, 32'd1);

        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
